// File: rtl/mem_readback_serializer_pkg.sv
// Shared SPI memory-access protocol definitions: widths, mem_sel encodings, bytes per word,
// readback FSM encoding and address wrap helper. Also used by the receive-side decoder.
package mem_readback_serializer_pkg;

    localparam int unsigned WIDTH_SPI_WORD   = 8;
    localparam int unsigned WIDTH_ADDR_ACT   = 11;
    localparam int unsigned WIDTH_ACT_MEM    = 8;
    localparam int unsigned WIDTH_ADDR_PARAM = 13;
    localparam int unsigned WIDTH_PARAM_MEM  = 128;
    localparam int unsigned WIDTH_ADDR_INST  = 6;
    localparam int unsigned WIDTH_INST_MEM   = 80;
    localparam int unsigned WIDTH_BURST      = 12;

    typedef enum logic [1:0] {
        MEM_REG   = 2'b00,
        MEM_PARAM = 2'b01,
        MEM_ACT   = 2'b10,
        MEM_INST  = 2'b11
    } mem_sel_e;

    localparam int unsigned BYTES_ACT   = (WIDTH_ACT_MEM + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
    localparam int unsigned BYTES_PARAM = (WIDTH_PARAM_MEM + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
    localparam int unsigned BYTES_INST  = (WIDTH_INST_MEM + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
    localparam int unsigned WIDTH_SHIFT = BYTES_PARAM * WIDTH_SPI_WORD;
    localparam int unsigned WIDTH_BCNT  = $clog2(BYTES_PARAM + 1);

    localparam logic [WIDTH_ADDR_PARAM-1:0] ADDR_MASK_ACT  =
        WIDTH_ADDR_PARAM'((1 << WIDTH_ADDR_ACT) - 1);
    localparam logic [WIDTH_ADDR_PARAM-1:0] ADDR_MASK_INST =
        WIDTH_ADDR_PARAM'((1 << WIDTH_ADDR_INST) - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;
    localparam logic [2:0] ST_CSUM  = 3'd7;

    // Truncate an address to the address width of the selected memory.
    function automatic logic [WIDTH_ADDR_PARAM-1:0] addr_wrap(
        input mem_sel_e                    sel,
        input logic [WIDTH_ADDR_PARAM-1:0] addr
    );
        case (sel)
            MEM_ACT:  addr_wrap = addr & ADDR_MASK_ACT;
            MEM_INST: addr_wrap = addr & ADDR_MASK_INST;
            default:  addr_wrap = addr;
        endcase
    endfunction

endpackage

// File: rtl/mem_readback_serializer_if.sv
// Command, memory read port and TX FIFO signals of the readback serializer.
// master: decoder/memories/FIFO side; slave: the serializer.
interface mem_readback_serializer_if;
    import mem_readback_serializer_pkg::*;

    logic                        start;
    logic [1:0]                  mem_sel;
    logic [WIDTH_ADDR_PARAM-1:0] start_addr;
    logic [WIDTH_BURST-1:0]      burst_len;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic                        act_rd_en;
    logic [WIDTH_ADDR_ACT-1:0]   act_rd_addr;
    logic [WIDTH_ACT_MEM-1:0]    act_rd_data;
    logic                        param_rd_en;
    logic [WIDTH_ADDR_PARAM-1:0] param_rd_addr;
    logic [WIDTH_PARAM_MEM-1:0]  param_rd_data;
    logic                        inst_rd_en;
    logic [WIDTH_ADDR_INST-1:0]  inst_rd_addr;
    logic [WIDTH_INST_MEM-1:0]   inst_rd_data;
    logic [WIDTH_SPI_WORD-1:0]   tx_data;
    logic                        tx_wr_req;
    logic                        tx_full;

    modport master (
        output start, mem_sel, start_addr, burst_len,
        output act_rd_data, param_rd_data, inst_rd_data, tx_full,
        input  busy, done, err,
        input  act_rd_en, act_rd_addr, param_rd_en, param_rd_addr, inst_rd_en, inst_rd_addr,
        input  tx_data, tx_wr_req
    );

    modport slave (
        input  start, mem_sel, start_addr, burst_len,
        input  act_rd_data, param_rd_data, inst_rd_data, tx_full,
        output busy, done, err,
        output act_rd_en, act_rd_addr, param_rd_en, param_rd_addr, inst_rd_en, inst_rd_addr,
        output tx_data, tx_wr_req
    );

endinterface

// File: rtl/mem_readback_serializer_byte_slicer.sv
// Wide-word to byte slicer: loads a left-aligned word, then emits it MSB byte first,
// one byte per cycle while the downstream FIFO is not full.
module mem_readback_serializer_byte_slicer #(
    parameter int unsigned WIDTH_WORD = 128,
    parameter int unsigned WIDTH_BYTE = 8,
    parameter int unsigned WIDTH_CNT  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [WIDTH_WORD-1:0] i_load_data,
    input  logic [WIDTH_CNT-1:0]  i_load_bytes,
    input  logic                  i_shift_en,
    input  logic                  i_tx_full,
    output logic [WIDTH_BYTE-1:0] o_byte,
    output logic                  o_push,
    output logic                  o_last
);

    logic [WIDTH_WORD-1:0] r_shift;
    logic [WIDTH_CNT-1:0]  r_byte_cnt;
    logic                  w_push;

    // Gated combinationally so a push never coincides with a full FIFO.
    assign w_push = i_shift_en && !i_tx_full && (r_byte_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_load_data;
            r_byte_cnt <= i_load_bytes;
        end else if (w_push) begin
            r_shift    <= r_shift << WIDTH_BYTE;
            r_byte_cnt <= r_byte_cnt - WIDTH_CNT'(1);
        end
    end

    assign o_byte = r_shift[WIDTH_WORD-1 -: WIDTH_BYTE];
    assign o_push = w_push;
    assign o_last = w_push && (r_byte_cnt == WIDTH_CNT'(1));

endmodule

// File: rtl/mem_readback_serializer.sv
// SPI readback path: reads act/param/inst memory words and pushes them MSB byte first into
// the TX FIFO. Define READBACK_CHECKSUM_EN to append an XOR checksum byte per command.
module mem_readback_serializer
    import mem_readback_serializer_pkg::*;
(
    input logic                      clk,
    input logic                      reset_n,
    mem_readback_serializer_if.slave bus
);

    logic [2:0]                  r_state;
    mem_sel_e                    r_sel;
    logic [WIDTH_ADDR_PARAM-1:0] r_addr;
    logic [WIDTH_BURST-1:0]      r_burst;
    logic [WIDTH_BURST-1:0]      r_word_cnt;
    logic                        r_err;

    logic [WIDTH_SHIFT-1:0]      w_load_data;
    logic [WIDTH_BCNT-1:0]       w_load_bytes;
    logic [WIDTH_SPI_WORD-1:0]   w_byte;
    logic                        w_push;
    logic                        w_last;

    // Narrow words are zero-padded to whole bytes, then left-aligned in the shift register.
    always_comb begin
        w_load_data  = '0;
        w_load_bytes = '0;
        case (r_sel)
            MEM_ACT: begin
                w_load_data  = WIDTH_SHIFT'(bus.act_rd_data) <<
                               (WIDTH_SHIFT - BYTES_ACT * WIDTH_SPI_WORD);
                w_load_bytes = WIDTH_BCNT'(BYTES_ACT);
            end
            MEM_PARAM: begin
                w_load_data  = WIDTH_SHIFT'(bus.param_rd_data);
                w_load_bytes = WIDTH_BCNT'(BYTES_PARAM);
            end
            MEM_INST: begin
                w_load_data  = WIDTH_SHIFT'(bus.inst_rd_data) <<
                               (WIDTH_SHIFT - BYTES_INST * WIDTH_SPI_WORD);
                w_load_bytes = WIDTH_BCNT'(BYTES_INST);
            end
            default: ;
        endcase
    end

    mem_readback_serializer_byte_slicer #(
        .WIDTH_WORD (WIDTH_SHIFT),
        .WIDTH_BYTE (WIDTH_SPI_WORD),
        .WIDTH_CNT  (WIDTH_BCNT)
    ) u_byte_slicer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (r_state == ST_LOAD),
        .i_load_data  (w_load_data),
        .i_load_bytes (w_load_bytes),
        .i_shift_en   (r_state == ST_SHIFT),
        .i_tx_full    (bus.tx_full),
        .o_byte       (w_byte),
        .o_push       (w_push),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= MEM_REG;
            r_addr     <= '0;
            r_burst    <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (mem_sel_e'(bus.mem_sel) == MEM_REG) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel      <= mem_sel_e'(bus.mem_sel);
                            r_addr     <= addr_wrap(mem_sel_e'(bus.mem_sel), bus.start_addr);
                            r_burst    <= bus.burst_len;
                            r_word_cnt <= '0;
                            r_state    <= ST_RD;
                        end
                    end
                end
                ST_RD:    r_state <= ST_WAIT;
                ST_WAIT:  r_state <= ST_LOAD;
                ST_LOAD:  r_state <= ST_SHIFT;
                ST_SHIFT: if (w_last) r_state <= ST_NEXT;
                ST_NEXT: begin
                    if (r_word_cnt == r_burst) begin
`ifdef READBACK_CHECKSUM_EN
                        r_state <= ST_CSUM;
`else
                        r_state <= ST_FIN;
`endif
                    end else begin
                        r_addr     <= addr_wrap(r_sel, r_addr + WIDTH_ADDR_PARAM'(1));
                        r_word_cnt <= r_word_cnt + WIDTH_BURST'(1);
                        r_state    <= ST_RD;
                    end
                end
`ifdef READBACK_CHECKSUM_EN
                ST_CSUM:  if (!bus.tx_full) r_state <= ST_FIN;
`endif
                ST_FIN:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign bus.done          = (r_state == ST_FIN);
    assign bus.err           = r_err;
    assign bus.act_rd_en     = (r_state == ST_RD) && (r_sel == MEM_ACT);
    assign bus.param_rd_en   = (r_state == ST_RD) && (r_sel == MEM_PARAM);
    assign bus.inst_rd_en    = (r_state == ST_RD) && (r_sel == MEM_INST);
    assign bus.act_rd_addr   = r_addr[WIDTH_ADDR_ACT-1:0];
    assign bus.param_rd_addr = r_addr;
    assign bus.inst_rd_addr  = r_addr[WIDTH_ADDR_INST-1:0];

`ifdef READBACK_CHECKSUM_EN
    logic [WIDTH_SPI_WORD-1:0] r_csum;
    logic                      w_csum_push;

    assign w_csum_push = (r_state == ST_CSUM) && !bus.tx_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum <= '0;
        end else if ((r_state == ST_IDLE) && bus.start &&
                     (mem_sel_e'(bus.mem_sel) != MEM_REG)) begin
            r_csum <= '0;
        end else if (w_push) begin
            r_csum <= r_csum ^ w_byte;
        end
    end

    assign bus.tx_wr_req = w_push || w_csum_push;
    assign bus.tx_data   = (r_state == ST_CSUM) ? r_csum : w_byte;
`else
    assign bus.tx_wr_req = w_push;
    assign bus.tx_data   = w_byte;
`endif

endmodule

// File: tb/tb_mem_readback_serializer.sv
// Self-checking bench: memory models, byte/read-address scoreboards, per-scenario tasks.
module tb_mem_readback_serializer;

`ifdef READBACK_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_readback_serializer_if bus ();

    mem_readback_serializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0]   act_mem   [0:2047];
    logic [127:0] param_mem [0:8191];
    logic [79:0]  inst_mem  [0:63];

    // Synchronous RAMs, one cycle read latency, output held between reads.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.act_rd_data   <= '0;
            bus.param_rd_data <= '0;
            bus.inst_rd_data  <= '0;
        end else begin
            if (bus.act_rd_en)   bus.act_rd_data   <= act_mem[bus.act_rd_addr];
            if (bus.param_rd_en) bus.param_rd_data <= param_mem[bus.param_rd_addr];
            if (bus.inst_rd_en)  bus.inst_rd_data  <= inst_mem[bus.inst_rd_addr];
        end
    end

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pushes = 0;
    int n_rd = 0;
    int n_done = 0;
    int n_err = 0;
    int last_done_cyc = 0;
    int push_cyc [0:4095];
    int rd_cyc [0:4095];
    logic [7:0]  exp_q    [$];
    logic [14:0] exp_rd_q [$];

    task automatic monitor();
        logic [7:0]  eb;
        logic [14:0] er;
        logic [14:0] got_rd;
        int          n_en;
        forever begin
            @(negedge clk);
            if (bus.tx_wr_req) begin
                push_cyc[n_pushes % 4096] = cyc;
                n_pushes++;
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL push_unexpected got=%02h expected=none", bus.tx_data);
                end else begin
                    eb = exp_q.pop_front();
                    if (bus.tx_data !== eb) begin
                        n_bad++;
                        $display("FAIL push_data got=%02h expected=%02h", bus.tx_data, eb);
                    end
                end
                n_total++;
                if (bus.tx_full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL push_while_full tx_full=%b expected=0", bus.tx_full);
                end
            end
            n_en = int'(bus.act_rd_en) + int'(bus.param_rd_en) + int'(bus.inst_rd_en);
            if (n_en != 0) begin
                rd_cyc[n_rd % 4096] = cyc;
                n_rd++;
                got_rd = bus.act_rd_en   ? {2'b10, 13'(bus.act_rd_addr)} :
                         bus.param_rd_en ? {2'b01, bus.param_rd_addr} :
                                           {2'b11, 13'(bus.inst_rd_addr)};
                n_total++;
                if (n_en != 1 || exp_rd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_unexpected enables=%0d got=%h", n_en, got_rd);
                end else begin
                    er = exp_rd_q.pop_front();
                    if (got_rd !== er) begin
                        n_bad++;
                        $display("FAIL rd_port_addr got=%h expected=%h", got_rd, er);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (bus.err === 1'b1) n_err++;
        end
    endtask

    // Expected read addresses and bytes (plus optional checksum) for one command.
    task automatic expect_cmd(input logic [1:0] sel, input logic [12:0] addr, input int burst);
        logic [12:0]  a;
        logic [127:0] w;
        logic [7:0]   x;
        int           nb;
        x = 8'h00;
        for (int k = 0; k <= burst; k++) begin
            a = addr + 13'(k);
            case (sel)
                2'b10: begin a = a & 13'h7FF; w = {120'b0, act_mem[a[10:0]]}; nb = 1; end
                2'b01: begin w = param_mem[a]; nb = 16; end
                default: begin a = a & 13'h3F; w = {48'b0, inst_mem[a[5:0]]}; nb = 10; end
            endcase
            exp_rd_q.push_back({sel, a});
            for (int b = nb - 1; b >= 0; b--) begin
                exp_q.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
        if (CSUM) exp_q.push_back(x);
    endtask

    task automatic start_cmd(input logic [1:0] sel, input logic [12:0] addr, input int burst);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.mem_sel    = sel;
        bus.start_addr = addr;
        bus.burst_len  = 12'(burst);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.busy, bus.done, bus.err, bus.tx_wr_req} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_status got=%b expected=0000",
                     {bus.busy, bus.done, bus.err, bus.tx_wr_req});
        end
        n_total++;
        if ({bus.act_rd_en, bus.param_rd_en, bus.inst_rd_en} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_rd_en got=%b expected=000",
                     {bus.act_rd_en, bus.param_rd_en, bus.inst_rd_en});
        end
        n_total++;
        if (bus.tx_data !== 8'h00 || bus.param_rd_addr !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_data got=%h/%h expected=0/0", bus.tx_data, bus.param_rd_addr);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] sel,
                                 input logic [12:0] addr, input int burst, input int nbytes);
        int base_p, base_d;
        bit ok;
        base_p = n_pushes;
        base_d = n_done;
        expect_cmd(sel, addr, burst);
        start_cmd(sel, addr, burst);
        wait_done(2000, ok);
        n_total++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_done_timeout got=no_done expected=done", name);
        end
        n_total++;
        if (n_pushes - base_p != nbytes + int'(CSUM)) begin
            n_bad++;
            $display("FAIL %s_push_count got=%0d expected=%0d", name, n_pushes - base_p,
                     nbytes + int'(CSUM));
        end
        n_total++;
        if (n_done - base_d != 1) begin
            n_bad++;
            $display("FAIL %s_done_count got=%0d expected=1", name, n_done - base_d);
        end
        n_total++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover bytes=%0d reads=%0d expected=0/0", name, exp_q.size(),
                     exp_rd_q.size());
        end
    endtask

    task automatic test_act_single();
        int base_p, base_r;
        base_p = n_pushes;
        base_r = n_rd;
        act_mem[5] = 8'hA7;
        run_and_check("act_single", 2'b10, 13'h005, 0, 1);
        // RD -> WAIT -> LOAD -> first SHIFT push
        n_total++;
        if (push_cyc[base_p] - rd_cyc[base_r] != 3) begin
            n_bad++;
            $display("FAIL act_push_latency got=%0d expected=3",
                     push_cyc[base_p] - rd_cyc[base_r]);
        end
        n_total++;
        if (last_done_cyc - push_cyc[n_pushes - 1] != (CSUM ? 1 : 2)) begin
            n_bad++;
            $display("FAIL act_done_latency got=%0d expected=%0d",
                     last_done_cyc - push_cyc[n_pushes - 1], CSUM ? 1 : 2);
        end
    endtask

    task automatic test_param_burst();
        param_mem[13'h10] = 128'h00112233445566778899AABBCCDDEEFF;
        param_mem[13'h11] = 128'h0F0E0D0C0B0A09080706050403020100;
        run_and_check("param_burst", 2'b01, 13'h0010, 1, 32);
    endtask

    task automatic test_inst_wrap();
        inst_mem[63] = 80'hA1A2A3A4A5A6A7A8A9AA;
        inst_mem[0]  = 80'h5B5C5D5E5F6061626364;
        run_and_check("inst_wrap", 2'b11, 13'h003F, 1, 20);
    endtask

    task automatic test_stall();
        int base_p, guard;
        bit ok;
        base_p = n_pushes;
        expect_cmd(2'b01, 13'h0010, 1);
        start_cmd(2'b01, 13'h0010, 1);
        guard = 0;
        while (n_pushes < base_p + 3 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1 bus.tx_full = 1'b1;
        repeat (5) @(posedge clk);
        n_total++;
        if (n_pushes - base_p != 3) begin
            n_bad++;
            $display("FAIL stall_pushes got=%0d expected=3", n_pushes - base_p);
        end
        #1 bus.tx_full = 1'b0;
        wait_done(2000, ok);
        n_total++;
        if (!ok || n_pushes - base_p != 32 + int'(CSUM) || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_total got=%0d done=%0b expected=%0d done=1", n_pushes - base_p,
                     ok, 32 + int'(CSUM));
        end
    endtask

    task automatic test_err();
        int base_p, base_r, base_e;
        base_p = n_pushes;
        base_r = n_rd;
        base_e = n_err;
        start_cmd(2'b00, 13'h0005, 0);
        @(negedge clk);
        n_total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse got err=%b busy=%b expected err=1 busy=0", bus.err, bus.busy);
        end
        repeat (10) @(negedge clk);
        n_total++;
        if (n_err - base_e != 1 || n_pushes != base_p || n_rd != base_r || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_side_effects got err_cycles=%0d pushes=%0d reads=%0d expected=1/0/0",
                     n_err - base_e, n_pushes - base_p, n_rd - base_r);
        end
    endtask

    task automatic test_busy_ignore();
        int base_p, base_d;
        bit ok;
        base_p = n_pushes;
        base_d = n_done;
        act_mem[13'h20] = 8'h01;
        act_mem[13'h21] = 8'h02;
        act_mem[13'h22] = 8'h04;
        expect_cmd(2'b10, 13'h0020, 2);
        start_cmd(2'b10, 13'h0020, 2);
        start_cmd(2'b01, 13'h0010, 0);
        wait_done(2000, ok);
        repeat (10) @(negedge clk);
        n_total++;
        if (!ok || n_pushes - base_p != 3 + int'(CSUM) || n_done - base_d != 1) begin
            n_bad++;
            $display("FAIL busy_ignore got pushes=%0d dones=%0d expected=%0d/1",
                     n_pushes - base_p, n_done - base_d, 3 + int'(CSUM));
        end
        n_total++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL busy_leftover bytes=%0d reads=%0d expected=0/0", exp_q.size(),
                     exp_rd_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int base_p, base_d, guard;
        base_p = n_pushes;
        base_d = n_done;
        expect_cmd(2'b01, 13'h0010, 3);
        start_cmd(2'b01, 13'h0010, 3);
        guard = 0;
        while (n_pushes < base_p + 5 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1 reset_n = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        @(negedge clk);
        n_total++;
        if ({bus.busy, bus.done, bus.tx_wr_req, bus.param_rd_en} !== 4'b0 ||
            bus.tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got=%b data=%02h expected=0000 data=00",
                     {bus.busy, bus.done, bus.tx_wr_req, bus.param_rd_en}, bus.tx_data);
        end
        base_p = n_pushes;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (40) @(negedge clk);
        n_total++;
        if (n_done != base_d || n_pushes != base_p || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_abort got dones=%0d pushes=%0d expected=0/0",
                     n_done - base_d, n_pushes - base_p);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.mem_sel    = 2'b00;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.tx_full    = 1'b0;
        fork
            monitor();
            forever begin
                @(posedge clk);
                cyc++;
            end
            begin
                #2_000_000;
                $display("FAIL global_timeout got=running expected=finished");
                $fatal(1, "bench timeout");
            end
        join_none
        test_reset();
        test_act_single();
        test_param_burst();
        test_inst_wrap();
        test_stall();
        test_err();
        test_busy_ignore();
        test_reset_mid();
        test_act_single();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
